// File: rtl/bram_pkg.sv
// Shared constants for the parameterised synchronous block RAM: read-during-write
// modes, sequencer state encoding and the address-width helper.
package bram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Address width for a given depth, never below one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset sweep sequencer: walks every address once in CLEAR, then opens
// the user ports by raising ready.
module bram_clear_seq
    import bram_pkg::*;
#(
    parameter int  DEPTH          = 1024,
    parameter bit  CLEAR_ON_RESET = 1'b1,
    localparam int AW             = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ready,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr
);

    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
    localparam state_e        RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;

    // NOTE: flops are updated with <= only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // NOTE: each combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
        ready_d = (state_d == RUN);
    end

    always_comb begin
        ready      = ready_q;
        sweep_we   = (state_q == CLEAR) && !rst;
        sweep_addr = cnt_q;
    end

endmodule

// File: rtl/bram_sync_param.sv
// Single-clock simple dual-port block RAM with per-bit write mask, selectable
// read-during-write behaviour and an optional post-reset clear sweep.
module bram_sync_param
    import bram_pkg::*;
#(
    parameter int               WIDTH          = 4,
    parameter int               DEPTH          = 1024,
    parameter int               RDW_MODE       = RDW_OLD,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0,
    localparam int              AW             = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] wmask
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic             sweep_we;
    logic [AW-1:0]    sweep_addr;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             rd_in_range, wr_in_range;
    logic             rd_acc, wr_acc;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata, mem_bit_en, rd_word;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    bram_clear_seq #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    always_comb begin
        rd_in_range = ({1'b0, raddr} < DEPTH_W);
        wr_in_range = ({1'b0, waddr} < DEPTH_W);
        rd_acc      = re && ready && !rst;
        wr_acc      = we && ready && !rst && wr_in_range;

        // The sweep owns the write port while it runs; user writes are blocked by ready=0.
        mem_we      = sweep_we || wr_acc;
        mem_addr    = sweep_we ? sweep_addr : waddr;
        mem_wdata   = sweep_we ? CLEAR_VALUE : wdata;
        mem_bit_en  = sweep_we ? '1 : ~wmask;

        rd_word     = rd_in_range ? mem[raddr] : '0;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        if (rd_acc) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            if ((RDW_MODE == RDW_NEW) && wr_acc && (waddr == raddr)) begin
                rdata_d = (rd_word & wmask) | (wdata & ~wmask);
            end
        end
    end

    // NOTE: the array itself is never reset; the sweep clears it, keeping it mappable to block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (mem_bit_en[i]) begin
                    mem[mem_addr][i] <= mem_wdata[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_bram_sync_param.sv
// Directed bench for bram_sync_param: four instances (old-data, new-data,
// non-power-of-two depth, no-clear) share one stimulus stream.
module tb_bram_sync_param;
    import bram_pkg::*;

    localparam int W  = 4;
    localparam int AW = 4;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          re = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [AW-1:0] waddr = '0;
    logic [W-1:0]  wdata = '0;
    logic [W-1:0]  wmask = '0;

    logic          ready_o  [ND];
    logic [W-1:0]  rdata_o  [ND];
    logic          rvalid_o [ND];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // 0: DEPTH 16, old data on read-during-write
    bram_sync_param #(.WIDTH(W), .DEPTH(16), .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(4'hA)) u_old (
        .clk(clk), .rst(rst), .ready(ready_o[0]), .re(re), .raddr(raddr), .rdata(rdata_o[0]), .rvalid(rvalid_o[0]),
        .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask));
    // 1: DEPTH 16, new data on read-during-write
    bram_sync_param #(.WIDTH(W), .DEPTH(16), .RDW_MODE(RDW_NEW), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(4'hA)) u_new (
        .clk(clk), .rst(rst), .ready(ready_o[1]), .re(re), .raddr(raddr), .rdata(rdata_o[1]), .rvalid(rvalid_o[1]),
        .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask));
    // 2: DEPTH 12, so addresses 12..15 are out of range
    bram_sync_param #(.WIDTH(W), .DEPTH(12), .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(4'h5)) u_d12 (
        .clk(clk), .rst(rst), .ready(ready_o[2]), .re(re), .raddr(raddr), .rdata(rdata_o[2]), .rvalid(rvalid_o[2]),
        .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask));
    // 3: no clear sweep
    bram_sync_param #(.WIDTH(W), .DEPTH(16), .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(4'hA)) u_nocl (
        .clk(clk), .rst(rst), .ready(ready_o[3]), .re(re), .raddr(raddr), .rdata(rdata_o[3]), .rvalid(rvalid_o[3]),
        .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until each instance raises ready and compares against the expected latency.
    task automatic check_rise(input string tag, input int exp0, input int exp1, input int exp2, input int exp3);
        int rise [ND];
        int exp_rise [ND];
        exp_rise = '{exp0, exp1, exp2, exp3};
        for (int d = 0; d < ND; d++) rise[d] = 0;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (t == 8) begin re = 1'b0; we = 1'b0; end
            for (int d = 0; d < ND; d++) if (ready_o[d] === 1'b1 && rise[d] == 0) rise[d] = t;
        end
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (rise[d] !== exp_rise[d]) begin
                n_fail++;
                $display("FAIL %s dut%0d: ready rose after %0d cycles, expected %0d", tag, d, rise[d], exp_rise[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; re = 1'b1; we = 1'b0; raddr = '0;
        tick();
        tick();
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (ready_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b want 0", d, ready_o[d]); end
            n_checks++;
            if (rvalid_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid dut%0d: got %b want 0", d, rvalid_o[d]); end
            n_checks++;
            if (rdata_o[d] !== 4'h0) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata_o[d]); end
        end
    endtask

    // Requests held during the first 8 sweep cycles must be ignored by the sweeping instances.
    task automatic test_sweep_blocked();
        bit saw_rvalid [3];
        for (int d = 0; d < 3; d++) saw_rvalid[d] = 1'b0;
        re = 1'b1; we = 1'b1; raddr = 4'd2; waddr = 4'd2; wdata = 4'h0; wmask = 4'h0;
        rst = 1'b0;
        fork
            check_rise("sweep_latency", 16, 16, 12, 1);
            for (int t = 1; t <= 9; t++) begin
                @(posedge clk);
                #2;
                for (int d = 0; d < 3; d++) if (rvalid_o[d] !== 1'b0) saw_rvalid[d] = 1'b1;
            end
        join
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (saw_rvalid[d] !== 1'b0) begin n_fail++; $display("FAIL blocked_rvalid dut%0d: rvalid seen while not ready", d); end
        end
    endtask

    task automatic test_sweep_contents();
        logic [W-1:0] exp2;
        re = 1'b1;
        for (int a = 0; a < 16; a++) begin
            raddr = AW'(a);
            tick();
            exp2 = (a < 12) ? 4'h5 : 4'h0;
            n_checks++;
            if (rvalid_o[0] !== 1'b1) begin n_fail++; $display("FAIL sweep_rvalid addr %0d: got %b want 1", a, rvalid_o[0]); end
            n_checks++;
            if (rdata_o[0] !== 4'hA) begin n_fail++; $display("FAIL sweep_data dut0 addr %0d: got %h want a", a, rdata_o[0]); end
            n_checks++;
            if (rdata_o[1] !== 4'hA) begin n_fail++; $display("FAIL sweep_data dut1 addr %0d: got %h want a", a, rdata_o[1]); end
            n_checks++;
            if (rdata_o[2] !== exp2) begin n_fail++; $display("FAIL sweep_data dut2 addr %0d: got %h want %h", a, rdata_o[2], exp2); end
            n_checks++;
            if (rvalid_o[2] !== 1'b1) begin n_fail++; $display("FAIL sweep_rvalid dut2 addr %0d: got %b want 1", a, rvalid_o[2]); end
        end
        re = 1'b0; raddr = 4'd3;
        tick();
        n_checks++;
        if (rvalid_o[0] !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid: got %b want 0", rvalid_o[0]); end
        n_checks++;
        if (rdata_o[2] !== 4'h0) begin n_fail++; $display("FAIL idle_hold dut2: got %h want 0", rdata_o[2]); end
    endtask

    task automatic test_masked_write();
        we = 1'b1; waddr = 4'd3; wdata = 4'hF; wmask = 4'b0101;
        tick();
        waddr = 4'd4; wdata = 4'h5; wmask = 4'b0011;
        tick();
        we = 1'b0; re = 1'b1; raddr = 4'd3;
        tick();
        n_checks++;
        if (rdata_o[0] !== 4'hA) begin n_fail++; $display("FAIL mask_addr3 dut0: got %h want a", rdata_o[0]); end
        n_checks++;
        if (rdata_o[2] !== 4'hF) begin n_fail++; $display("FAIL mask_addr3 dut2: got %h want f", rdata_o[2]); end
        raddr = 4'd4;
        tick();
        n_checks++;
        if (rdata_o[0] !== 4'h6) begin n_fail++; $display("FAIL mask_addr4 dut0: got %h want 6", rdata_o[0]); end
        n_checks++;
        if (rdata_o[2] !== 4'h5) begin n_fail++; $display("FAIL mask_addr4 dut2: got %h want 5", rdata_o[2]); end
        re = 1'b0; wmask = 4'h0;
        tick();
    endtask

    task automatic test_rdw();
        we = 1'b1; waddr = 4'd5; wdata = 4'h3; wmask = 4'h0;
        tick();
        re = 1'b1; raddr = 4'd5; wdata = 4'hC;
        tick();
        n_checks++;
        if (rdata_o[0] !== 4'h3) begin n_fail++; $display("FAIL rdw_old: got %h want 3", rdata_o[0]); end
        n_checks++;
        if (rdata_o[1] !== 4'hC) begin n_fail++; $display("FAIL rdw_new: got %h want c", rdata_o[1]); end
        we = 1'b0;
        tick();
        n_checks++;
        if (rdata_o[0] !== 4'hC) begin n_fail++; $display("FAIL rdw_after dut0: got %h want c", rdata_o[0]); end
        raddr = 4'd6; we = 1'b1; waddr = 4'd6; wdata = 4'h5; wmask = 4'b1100;
        tick();
        n_checks++;
        if (rdata_o[0] !== 4'hA) begin n_fail++; $display("FAIL rdw_mask_old: got %h want a", rdata_o[0]); end
        n_checks++;
        if (rdata_o[1] !== 4'h9) begin n_fail++; $display("FAIL rdw_mask_new: got %h want 9", rdata_o[1]); end
        we = 1'b0; re = 1'b0; wmask = 4'h0;
        tick();
    endtask

    task automatic test_out_of_range();
        logic [W-1:0] exp2;
        we = 1'b1; waddr = 4'd13; wdata = 4'h9; wmask = 4'h0;
        tick();
        we = 1'b0; re = 1'b1; raddr = 4'd13;
        tick();
        n_checks++;
        if (rvalid_o[2] !== 1'b1) begin n_fail++; $display("FAIL oor_rvalid: got %b want 1", rvalid_o[2]); end
        n_checks++;
        if (rdata_o[2] !== 4'h0) begin n_fail++; $display("FAIL oor_rdata: got %h want 0", rdata_o[2]); end
        n_checks++;
        if (rdata_o[0] !== 4'h9) begin n_fail++; $display("FAIL inrange_13 dut0: got %h want 9", rdata_o[0]); end
        for (int a = 0; a < 12; a++) begin
            raddr = AW'(a);
            tick();
            exp2 = (a == 3) ? 4'hF : (a == 5) ? 4'hC : 4'h5;
            n_checks++;
            if (rdata_o[2] !== exp2) begin n_fail++; $display("FAIL oor_intact addr %0d: got %h want %h", a, rdata_o[2], exp2); end
        end
        re = 1'b0;
        tick();
    endtask

    // A read presented on the same edge as reset must not produce rvalid.
    task automatic test_rst_in_run();
        re = 1'b1; raddr = 4'd3; rst = 1'b1;
        tick();
        re = 1'b0;
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (rvalid_o[d] !== 1'b0) begin n_fail++; $display("FAIL rst_inflight dut%0d: rvalid %b want 0", d, rvalid_o[d]); end
            n_checks++;
            if (rdata_o[d] !== 4'h0) begin n_fail++; $display("FAIL rst_rdata dut%0d: got %h want 0", d, rdata_o[d]); end
        end
    endtask

    task automatic test_mid_sweep_reset();
        rst = 1'b0;
        for (int t = 0; t < 7; t++) tick();
        n_checks++;
        if (ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL midsweep_ready: got %b want 0", ready_o[0]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_rise("midsweep_latency", 16, 16, 12, 1);
        re = 1'b1; raddr = 4'd3;
        tick();
        n_checks++;
        if (rdata_o[0] !== 4'hA) begin n_fail++; $display("FAIL resweep_addr3 dut0: got %h want a", rdata_o[0]); end
        n_checks++;
        if (rdata_o[2] !== 4'h5) begin n_fail++; $display("FAIL resweep_addr3 dut2: got %h want 5", rdata_o[2]); end
        raddr = 4'd13;
        tick();
        n_checks++;
        if (rdata_o[0] !== 4'hA) begin n_fail++; $display("FAIL resweep_addr13 dut0: got %h want a", rdata_o[0]); end
        re = 1'b0;
        tick();
    endtask

    task automatic test_no_clear();
        we = 1'b1; waddr = 4'd9; wdata = 4'h7; wmask = 4'h0;
        tick();
        we = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (ready_o[3] !== 1'b1) begin n_fail++; $display("FAIL noclear_ready: got %b want 1", ready_o[3]); end
        n_checks++;
        if (ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL clear_ready_early: got %b want 0", ready_o[0]); end
        for (int t = 0; t < 15; t++) tick();
        n_checks++;
        if (ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL clear_ready_16: got %b want 1", ready_o[0]); end
        re = 1'b1; raddr = 4'd9;
        tick();
        n_checks++;
        if (rdata_o[3] !== 4'h7) begin n_fail++; $display("FAIL noclear_keep: got %h want 7", rdata_o[3]); end
        n_checks++;
        if (rvalid_o[3] !== 1'b1) begin n_fail++; $display("FAIL noclear_rvalid: got %b want 1", rvalid_o[3]); end
        n_checks++;
        if (rdata_o[0] !== 4'hA) begin n_fail++; $display("FAIL clear_wipe: got %h want a", rdata_o[0]); end
        re = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_sweep_blocked();
        test_sweep_contents();
        test_masked_write();
        test_rdw();
        test_out_of_range();
        test_rst_in_run();
        test_mid_sweep_reset();
        test_no_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
